// File: rtl/switch_sampler.sv
// Debounced switch snapshot with two-flop synchronizers, per-bit stability counters,
// a freezable output register and a handshake FSM on bit 8.
module switch_sampler #(
    parameter int SW_BITS         = 9,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SW_BITS-1:0] switches_raw,
    input  logic               freeze,
    output logic [SW_BITS-1:0] switches_out,
    output logic               sw8_rise,
    output logic               sw8_fall,
    output logic               stable
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int               HS_BIT  = 8;

    typedef enum logic {RELEASED, PRESSED} state_t;

    logic [SW_BITS-1:0] sync1_q, sync2_q;
    logic [SW_BITS-1:0] deb_q, deb_d;
    logic [CNT_W-1:0]   cnt_q [SW_BITS];
    logic [CNT_W-1:0]   cnt_d [SW_BITS];
    logic [SW_BITS-1:0] out_q;
    state_t             state_q, state_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;

    // Counter saturates at CNT_MAX: that is the edge the level is accepted, and it clears there.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < SW_BITS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            RELEASED: begin
                if (deb_q[HS_BIT]) begin
                    state_d = PRESSED;
                    rise_d  = 1'b1;
                end
            end
            PRESSED: begin
                if (!deb_q[HS_BIT]) begin
                    state_d = RELEASED;
                    fall_d  = 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            out_q   <= '0;
            state_q <= RELEASED;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            for (int i = 0; i < SW_BITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= switches_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            if (!freeze) begin
                out_q <= deb_q;
            end
            for (int i = 0; i < SW_BITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign switches_out = out_q;
    assign sw8_rise     = rise_q;
    assign sw8_fall     = fall_q;
    assign stable       = (sync2_q == deb_q);

endmodule

// File: tb/tb_switch_sampler.sv
// Bench for switch_sampler with DEBOUNCE_CYCLES=4: directed scenarios plus randomized
// traffic checked against a window-based reference model.
module tb_switch_sampler;

    localparam int D = 4;
    localparam int W = 9;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] switches_raw = '0;
    logic         freeze = 1'b0;
    logic [W-1:0] switches_out;
    logic         sw8_rise, sw8_fall, stable;

    int n_checks = 0;
    int n_pass   = 0;

    switch_sampler #(.SW_BITS(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .switches_raw(switches_raw), .freeze(freeze),
        .switches_out(switches_out), .sw8_rise(sw8_rise), .sw8_fall(sw8_fall), .stable(stable)
    );

    always #5 clk = ~clk;

    // Reference: a level is accepted once the last D synchronized samples all disagree with it.
    logic [W-1:0] m_s1, m_s2, m_deb, m_out;
    logic         m_lvl8, m_rise, m_fall, m_stable;
    logic [W-1:0] hist [$];

    task automatic model_step();
        logic [W-1:0] old_deb;
        logic         all_diff;
        old_deb = m_deb;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_out = '0;
            m_lvl8 = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            for (int i = 0; i < W; i++) begin
                all_diff = (hist.size() == D);
                foreach (hist[k]) if (hist[k][i] == old_deb[i]) all_diff = 1'b0;
                if (all_diff) m_deb[i] = ~old_deb[i];
            end
            m_rise = old_deb[8] & ~m_lvl8;
            m_fall = ~old_deb[8] & m_lvl8;
            m_lvl8 = old_deb[8];
            if (!freeze) m_out = old_deb;
            m_s2 = m_s1;
            m_s1 = switches_raw;
        end
        m_stable = (m_s2 == m_deb);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1; switches_raw = 9'h1FF; freeze = 1'b1;
        cycles(2);
        n_checks++;
        if ({switches_out, sw8_rise, sw8_fall, stable} !== {9'h000, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_state: out=%h rise=%b fall=%b stable=%b, want 000 0 0 1",
                     switches_out, sw8_rise, sw8_fall, stable);
        else n_pass++;
        reset = 1'b0; switches_raw = '0; freeze = 1'b0;
        cycles(3);
    endtask

    task automatic test_steady();
        switches_raw = 9'h0A5;
        for (int e = 1; e <= 10; e++) begin
            cyc();
            n_checks++;
            if (switches_out !== ((e >= 7) ? 9'h0A5 : 9'h000))
                $display("FAIL steady_out edge %0d: got %h want %h", e, switches_out,
                         (e >= 7) ? 9'h0A5 : 9'h000);
            else n_pass++;
            n_checks++;
            if ({stable, sw8_rise, sw8_fall} !== {(e == 1 || e >= 6), 1'b0, 1'b0})
                $display("FAIL steady_flags edge %0d: stable=%b rise=%b fall=%b want stable=%b no pulses",
                         e, stable, sw8_rise, sw8_fall, (e == 1 || e >= 6));
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        int lows = 0;
        for (int e = 1; e <= 10; e++) begin
            switches_raw = (e <= 3) ? 9'h0AD : 9'h0A5;
            cyc();
            if (!stable) lows++;
            n_checks++;
            if (switches_out !== 9'h0A5 || stable !== !(e >= 2 && e <= 4))
                $display("FAIL glitch edge %0d: out=%h stable=%b want 0a5 %b", e, switches_out,
                         stable, !(e >= 2 && e <= 4));
            else n_pass++;
        end
        n_checks++;
        if (lows != 3) $display("FAIL glitch_stable_low: got %0d cycles want 3", lows);
        else n_pass++;
    endtask

    task automatic test_sw8();
        int rises = 0, falls = 0, at = 0;
        switches_raw = 9'h1A5;
        for (int e = 1; e <= 14; e++) begin
            cyc();
            if (sw8_rise) begin rises++; at = e; end
            if (sw8_fall) falls++;
            if (sw8_rise) begin
                n_checks++;
                if (switches_out[8] !== 1'b1) $display("FAIL sw8_rise_coincident: out[8]=%b want 1", switches_out[8]);
                else n_pass++;
            end
        end
        n_checks++;
        if (rises != 1 || falls != 0 || at != 7)
            $display("FAIL sw8_rise_count: rises=%0d falls=%0d edge=%0d want 1 0 7", rises, falls, at);
        else n_pass++;
        rises = 0; falls = 0; at = 0;
        switches_raw = 9'h0A5;
        for (int e = 1; e <= 14; e++) begin
            cyc();
            if (sw8_rise) rises++;
            if (sw8_fall) begin falls++; at = e; end
        end
        n_checks++;
        if (rises != 0 || falls != 1 || at != 7 || switches_out !== 9'h0A5)
            $display("FAIL sw8_fall_count: rises=%0d falls=%0d edge=%0d out=%h want 0 1 7 0a5",
                     rises, falls, at, switches_out);
        else n_pass++;
    endtask

    task automatic test_freeze();
        int rises = 0, bad = 0;
        switches_raw = 9'h011;
        cycles(10);
        n_checks++;
        if (switches_out !== 9'h011) $display("FAIL freeze_snapshot: got %h want 011", switches_out);
        else n_pass++;
        freeze = 1'b1; switches_raw = 9'h1FF;
        for (int e = 1; e <= 12; e++) begin
            cyc();
            if (sw8_rise) rises++;
            if (switches_out !== 9'h011) bad++;
        end
        n_checks++;
        if (bad != 0 || rises != 1)
            $display("FAIL freeze_hold: changed_cycles=%0d rises=%0d want 0 1", bad, rises);
        else n_pass++;
        freeze = 1'b0;
        cyc();
        n_checks++;
        if (switches_out !== 9'h1FF) $display("FAIL freeze_release: got %h want 1ff", switches_out);
        else n_pass++;
    endtask

    task automatic test_reset_pending();
        int at = 0, rises = 0;
        switches_raw = 9'h000;
        cycles(10);
        switches_raw = 9'h100;
        cycles(5);
        reset = 1'b1;
        cyc();
        n_checks++;
        if ({switches_out, sw8_rise, sw8_fall} !== {9'h000, 1'b0, 1'b0})
            $display("FAIL reset_pending: out=%h rise=%b fall=%b want 000 0 0", switches_out, sw8_rise, sw8_fall);
        else n_pass++;
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            cyc();
            if (sw8_rise) begin rises++; at = e; end
        end
        n_checks++;
        if (rises != 1 || at != 7) $display("FAIL reset_rise_latency: rises=%0d edge=%0d want 1 7", rises, at);
        else n_pass++;
    endtask

    task automatic test_bounce();
        logic [8:0] pat;
        int rises = 0, falls = 0;
        pat = 9'b111101101;
        switches_raw = 9'h000;
        cycles(10);
        for (int e = 0; e < 21; e++) begin
            switches_raw = (e < 9) ? {pat[e], 8'h00} : 9'h100;
            cyc();
            if (sw8_rise) rises++;
            if (sw8_fall) falls++;
        end
        n_checks++;
        if (rises != 1 || falls != 0) $display("FAIL bounce: rises=%0d falls=%0d want 1 0", rises, falls);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) switches_raw = W'($urandom);
            else if ($urandom_range(0, 7) == 0) switches_raw[$urandom_range(0, W-1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) freeze = ~freeze;
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            else reset = 1'b0;
            cyc();
            n_checks++;
            if ({switches_out, sw8_rise, sw8_fall, stable} !== {m_out, m_rise, m_fall, m_stable} ||
                (sw8_rise && sw8_fall)) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random cycle %0d: out=%h rise=%b fall=%b stable=%b want %h %b %b %b",
                             n, switches_out, sw8_rise, sw8_fall, stable, m_out, m_rise, m_fall, m_stable);
            end else n_pass++;
        end
        reset = 1'b0; freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_glitch();
        test_sw8();
        test_freeze();
        test_reset_pending();
        test_bounce();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/switch_sampler.md
SWITCH_SAMPLER -- requirements
Module: switch_sampler

Interface
REQ-001 SHALL have parameter SW_BITS, default `SWITCH_WIDTH-1 (9): number of sampled switch inputs; bit 8 is the handshake switch.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, legal range 2..65535: consecutive stable samples needed to accept a change.
REQ-003 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port switches_raw, input, SW_BITS: asynchronous board switch levels.
REQ-006 SHALL have port freeze, input, 1: when high, the snapshot is held for a multi-instruction read.
REQ-007 SHALL have port switches_out, output, SW_BITS: debounced snapshot; bits 7:0 feed the SW0-7 register slot and bit 8 feeds the SW8 slot.
REQ-008 SHALL have port sw8_rise, output, 1: one-cycle pulse on an accepted 0->1 of bit 8.
REQ-009 SHALL have port sw8_fall, output, 1: one-cycle pulse on an accepted 1->0 of bit 8.
REQ-010 SHALL have port stable, output, 1: high when no bit has a pending, unaccepted change.

Function
REQ-011 SHALL pass each bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-012 SHALL keep, per bit, a debounced level deb[i] and a counter cnt[i] of width clog2(DEBOUNCE_CYCLES).
REQ-013 SHALL clear cnt[i] on a cycle where sync2[i]==deb[i], and increment cnt[i] on a cycle where sync2[i]!=deb[i].
REQ-014 SHALL, on the cycle where sync2[i]!=deb[i] and cnt[i]==DEBOUNCE_CYCLES-1, invert deb[i] and clear cnt[i] on the same edge.
REQ-015 SHALL never let cnt[i] wrap or exceed DEBOUNCE_CYCLES-1.
REQ-016 SHALL, so that a glitch shorter than DEBOUNCE_CYCLES sync2 samples leaves deb unchanged, restart counting from 0 whenever sync2 returns to deb.
REQ-017 SHALL make deb[i] change DEBOUNCE_CYCLES+2 edges after a clean raw step, counting the first edge that samples the new value as edge 1.
REQ-018 SHALL load switches_out <= deb on every edge where freeze==0, giving one further cycle of latency.
REQ-019 SHALL hold switches_out while freeze==1, while debouncing continues; the first edge with freeze==0 loads the current deb.
REQ-020 SHALL run a two-state handshake FSM on deb[8], with states RELEASED and PRESSED.
REQ-021 SHALL, in RELEASED, move to PRESSED and assert sw8_rise for exactly one cycle when deb[8] becomes 1.
REQ-022 SHALL, in PRESSED, move to RELEASED and assert sw8_fall for exactly one cycle when deb[8] becomes 0.
REQ-023 SHALL register sw8_rise and sw8_fall, so they assert in the same cycle that switches_out[8] shows the new level when freeze==0.
REQ-024 SHALL generate sw8_rise and sw8_fall independently of freeze.
REQ-025 SHALL never assert sw8_rise and sw8_fall in the same cycle.
REQ-026 SHALL drive stable = 1 exactly when every sync2[i]==deb[i]; stable is combinational from registers.
REQ-027 SHALL debounce and report bits independently when several bits change in the same cycle.

Reset
REQ-028 SHALL, while reset==1 at a clock edge, clear sync1, sync2, deb, cnt and switches_out to 0, put the FSM in RELEASED, and clear sw8_rise and sw8_fall to 0.
REQ-029 SHALL give reset priority over freeze and over any pending debounce, including a counter at DEBOUNCE_CYCLES-1.
REQ-030 SHALL, after reset, treat switches held high as a fresh change: an accepted bit 8 of 1 produces sw8_rise.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Bench SHALL drive reset then switches_raw=0x0A5 steady -> switches_out=0x0A5 at edge 7 after the first sampling edge, stable high after, no sw8 pulses.
REQ-032 Bench SHALL apply a 3-cycle 1-pulse on bit 3 -> switches_out unchanged, and stable low only during the pulse plus 2 cycles.
REQ-033 Bench SHALL set bit 8 high steady -> single-cycle sw8_rise coincident with switches_out[8]=1; then set it low -> single sw8_fall.
REQ-034 Bench SHALL hold freeze=1 with a snapshot of 0x011 while raw changes to 0x1FF -> switches_out stays 0x011 and sw8_rise still pulses; freeze=0 -> next edge gives 0x1FF.
REQ-035 Bench SHALL assert reset with bit 8 cnt at 3 -> all outputs 0 next edge; with raw held 0x100, a later sw8_rise follows the REQ-017 latency.
REQ-036 Bench SHALL bounce bit 8 with pattern 1,0,1,1,0,1,1,1,1 -> exactly one sw8_rise, and no sw8_fall.
